// File: rtl/id_gen.sv
// rtl/id_gen.sv - letters-then-digits ASCII identifier generator with valid/ready output.
// Optional macro ID_GEN_SEP_EN appends a trailing space byte after each identifier.
module id_gen #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] letter_cnt,
  input  logic [CNT_W-1:0] digit_cnt,
  input  logic [4:0]       letter_seed,
  input  logic             upper,
  output logic [7:0]       char,
  output logic             valid,
  input  logic             ready,
  output logic             last,
  output logic             busy,
  output logic             done
);

`ifdef ID_GEN_SEP_EN
  typedef enum logic [1:0] {IDLE, LETTER, DIGIT, SEP} state_t;
  localparam bit SEP_EN = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, LETTER, DIGIT} state_t;
  localparam bit SEP_EN = 1'b0;
`endif

  state_t           state;
  logic [CNT_W-1:0] l_rem;
  logic [CNT_W-1:0] d_rem;
  logic [4:0]       idx;
  logic [3:0]       d;
  logic             upper_r;

  logic [4:0] seed_red;
  logic [4:0] idx_nxt;
  logic [3:0] d_nxt;

  assign seed_red = (letter_seed >= 5'd26) ? letter_seed - 5'd26 : letter_seed;
  assign idx_nxt  = (idx == 5'd25) ? 5'd0 : idx + 5'd1;
  assign d_nxt    = (d == 4'd9) ? 4'd0 : d + 4'd1;

  function automatic logic [7:0] letter_char(input logic up, input logic [4:0] i);
    letter_char = (up ? 8'h41 : 8'h61) + {3'b000, i};
  endfunction

  // char/last always hold the byte being offered; each transfer loads the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      l_rem   <= '0;
      d_rem   <= '0;
      idx     <= '0;
      d       <= '0;
      upper_r <= 1'b0;
      char    <= 8'h00;
      valid   <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && letter_cnt != '0) begin
            state   <= LETTER;
            l_rem   <= letter_cnt;
            d_rem   <= digit_cnt;
            idx     <= seed_red;
            d       <= '0;
            upper_r <= upper;
            char    <= letter_char(upper, seed_red);
            valid   <= 1'b1;
            busy    <= 1'b1;
            last    <= (letter_cnt == CNT_W'(1)) && (digit_cnt == '0) && !SEP_EN;
          end
        end
        LETTER: begin
          if (ready) begin
            if (l_rem != CNT_W'(1)) begin
              l_rem <= l_rem - CNT_W'(1);
              idx   <= idx_nxt;
              char  <= letter_char(upper_r, idx_nxt);
              last  <= (l_rem == CNT_W'(2)) && (d_rem == '0) && !SEP_EN;
            end else if (d_rem != '0) begin
              state <= DIGIT;
              d     <= '0;
              char  <= 8'h30;
              last  <= (d_rem == CNT_W'(1)) && !SEP_EN;
            end else begin
`ifdef ID_GEN_SEP_EN
              state <= SEP;
              char  <= 8'h20;
              last  <= 1'b1;
`else
              state <= IDLE;
              valid <= 1'b0;
              busy  <= 1'b0;
              last  <= 1'b0;
              done  <= 1'b1;
`endif
            end
          end
        end
        DIGIT: begin
          if (ready) begin
            if (d_rem != CNT_W'(1)) begin
              d_rem <= d_rem - CNT_W'(1);
              d     <= d_nxt;
              char  <= 8'h30 + {4'b0000, d_nxt};
              last  <= (d_rem == CNT_W'(2)) && !SEP_EN;
            end else begin
`ifdef ID_GEN_SEP_EN
              state <= SEP;
              char  <= 8'h20;
              last  <= 1'b1;
`else
              state <= IDLE;
              valid <= 1'b0;
              busy  <= 1'b0;
              last  <= 1'b0;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef ID_GEN_SEP_EN
        SEP: begin
          if (ready) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_id_gen.sv
// tb/tb_id_gen.sv - table-driven bench for id_gen with handshake and reset corner sequences.
module tb_id_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] letter_cnt = '0;
  logic [3:0] digit_cnt = '0;
  logic [4:0] letter_seed = '0;
  logic       upper = 1'b0;
  logic [7:0] char;
  logic       valid;
  logic       ready = 1'b1;
  logic       last;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail = 0;

  id_gen #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .letter_cnt(letter_cnt),
    .digit_cnt(digit_cnt), .letter_seed(letter_seed), .upper(upper),
    .char(char), .valid(valid), .ready(ready), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        l;
    int        d;
    int        seed;
    bit        up;
    bit [15:0] mask;
    string     exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Called at a negedge; issues start there and follows the stream to the done pulse.
  task automatic run_req(input int l, input int d, input int seed, input bit up,
                         input bit [15:0] mask, input string exp_in, input bit overlap);
    string exp;
    int    n;
    int    i;
    int    cyc;
    exp = exp_in;
`ifdef ID_GEN_SEP_EN
    exp = {exp, " "};
`endif
    n = exp.len();
    start = 1'b1; letter_cnt = 4'(l); digit_cnt = 4'(d); letter_seed = 5'(seed); upper = up;
    @(negedge clk);
    start = 1'b0;
    i = 0; cyc = 0;
    while (i < n && cyc < 400) begin
      ready = mask[cyc % 16];
      if (overlap && cyc == 1) begin
        start = 1'b1; letter_cnt = 4'd7; digit_cnt = 4'd7; letter_seed = 5'd9; upper = ~up;
      end else begin
        start = 1'b0;
      end
      check($sformatf("byte%0d of %s", i, exp),
            valid && busy && !done && char == exp[i] && last == (i == n - 1),
            {valid, busy, done, last, char}, {4'b1100 | 4'(i == n - 1), exp[i]});
      if (ready) i++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b1;
    check($sformatf("complete %s", exp), i == n, i, n);
    check($sformatf("done pulse %s", exp), !valid && !busy && done && !last,
          {valid, busy, done, last}, 4'b0010);
  endtask

  initial begin
    vecs[0] = '{3, 2, 0, 1'b0, 16'hFFFF, "abc01"};
    vecs[1] = '{4, 12, 24, 1'b1, 16'hFFFF, "YZAB012345678901"};
    vecs[2] = '{1, 0, 30, 1'b1, 16'hFFFF, "E"};
    vecs[3] = '{1, 0, 4, 1'b1, 16'hFFFF, "E"};
    vecs[4] = '{2, 1, 0, 1'b0, 16'hFFF4, "ab0"};
    vecs[5] = '{2, 3, 25, 1'b0, 16'h5555, "za012"};
    vecs[6] = '{15, 0, 0, 1'b0, 16'hFFFF, "abcdefghijklmno"};
    vecs[7] = '{1, 15, 31, 1'b0, 16'hFFFF, "f012345678901234"};

    #3;
    check("reset outputs", char == 8'h00 && !valid && !last && !busy && !done,
          {valid, busy, done, last, char}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors back to back: each start lands on the edge ending the previous done cycle.
    for (int v = 0; v < 8; v++)
      run_req(vecs[v].l, vecs[v].d, vecs[v].seed, vecs[v].up, vecs[v].mask, vecs[v].exp, 1'b0);
    @(negedge clk);
    check("done one cycle", !done && !busy && !valid, {valid, busy, done}, 3'b000);

    // Rejected request with letter_cnt of zero.
    start = 1'b1; letter_cnt = 4'd0; digit_cnt = 4'd3;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reject cycle%0d", k), !busy && !valid && !done, {valid, busy, done}, 3'b000);
      @(negedge clk);
    end

    // Overlapping start mid-request is ignored.
    run_req(3, 2, 0, 1'b0, 16'hFFFF, "abc01", 1'b1);
    @(negedge clk);
    check("no restart after overlap", !busy && !valid, {valid, busy}, 2'b00);

    // Reset while the third byte is offered.
    start = 1'b1; letter_cnt = 4'd5; digit_cnt = 4'd0; letter_seed = 5'd0; upper = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("pre-reset byte a", valid && char == 8'h61, {valid, char}, 9'h161);
    @(negedge clk);
    check("pre-reset byte b", valid && char == 8'h62, {valid, char}, 9'h162);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async abort", !valid && !busy && !done && char == 8'h00,
          {valid, busy, done, char}, 11'h000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("no done after abort%0d", k), !done && !valid, {valid, done}, 2'b00);
      @(negedge clk);
    end
    run_req(1, 0, 0, 1'b0, 16'hFFFF, "a", 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: actual running required finished");
    $fatal(1, "timeout");
  end
endmodule
